// File: rtl/dcc_duty_monitor.sv
// dcc_duty_monitor: oversamples the corrector's output clock with clk and
// accumulates high time and period over 2^N_PER_LOG2 full periods, then
// flags whether the duty cycle sits within a tolerance window around 50%.
module dcc_duty_monitor #(
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned N_PER_LOG2 = 2,
  parameter int unsigned TOL_SHIFT  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mon_clk_in,
  input  logic                          locked_in,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [CNT_W+N_PER_LOG2-1:0]   high_acc,
  output logic [CNT_W+N_PER_LOG2-1:0]   per_acc,
  output logic                          duty_ok,
  output logic                          err_timeout,
  output logic                          err_unlock
);

  localparam int unsigned AW = CNT_W + N_PER_LOG2;
  localparam int unsigned SW = AW + 2;
  localparam int unsigned PW = N_PER_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [PW-1:0]    PER_LAST = PW'((1 << N_PER_LOG2) - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOCK,
    ALIGN,
    MEASURE,
    REPORT
  } state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    pcnt;

  logic             rise_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic signed [SW-1:0] diff_c, mag_c, lim_c;
  logic             within_c;

  // Two-flop synchronizer on the monitored clock plus an edge-detect flop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= mon_clk_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_c    = s2 & ~s3;
  assign cnt_inc_c = cnt + CNT_W'(1);

  // Tolerance check |2*high - per| <= per >> TOL_SHIFT on the current accumulators
  always_comb begin
    diff_c   = signed'(SW'({high_acc, 1'b0})) - signed'(SW'(per_acc));
    mag_c    = diff_c[SW-1] ? -diff_c : diff_c;
    lim_c    = signed'(SW'(per_acc >> TOL_SHIFT));
    within_c = (mag_c <= lim_c);
  end

  // Measurement FSM; done is raised on the transition into REPORT so it is
  // visible for exactly the one cycle spent in REPORT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      high_acc    <= '0;
      per_acc     <= '0;
      duty_ok     <= 1'b0;
      err_timeout <= 1'b0;
      err_unlock  <= 1'b0;
      cnt         <= '0;
      pcnt        <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= WAIT_LOCK;
            busy        <= 1'b1;
            high_acc    <= '0;
            per_acc     <= '0;
            duty_ok     <= 1'b0;
            err_timeout <= 1'b0;
            err_unlock  <= 1'b0;
            cnt         <= '0;
            pcnt        <= '0;
          end
        end
        WAIT_LOCK: begin
          if (locked_in) begin
            state <= ALIGN;
            cnt   <= '0;
          end
        end
        ALIGN: begin
          if (rise_c) begin
            // The edge cycle is the first sample of the first measured period
            state    <= MEASURE;
            per_acc  <= AW'(1);
            high_acc <= AW'(s2);
            cnt      <= CNT_W'(1);
            pcnt     <= '0;
          end else if (cnt_inc_c == CNT_MAX) begin
            err_timeout <= 1'b1;
            state       <= REPORT;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        MEASURE: begin
          if (!locked_in) begin
            err_unlock <= 1'b1;
            if (!rise_c && (cnt_inc_c == CNT_MAX)) begin
              err_timeout <= 1'b1;
            end
            state <= REPORT;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (rise_c && (pcnt == PER_LAST)) begin
            // Closing edge: not accumulated, so the registers already hold the result
            duty_ok <= within_c;
            state   <= REPORT;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            per_acc  <= per_acc + AW'(1);
            high_acc <= high_acc + AW'(s2);
            if (rise_c) begin
              pcnt <= pcnt + PW'(1);
              cnt  <= CNT_W'(1);
            end else if (cnt_inc_c == CNT_MAX) begin
              err_timeout <= 1'b1;
              state       <= REPORT;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else begin
              cnt <= cnt_inc_c;
            end
          end
        end
        REPORT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcc_duty_monitor.sv
// Self-checking bench for dcc_duty_monitor: three instances share stimulus
// and differ only in TOL_SHIFT (4, 2, 3).
module tb_dcc_duty_monitor;

  localparam int unsigned AW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mon_clk_in;
  logic          locked_in;
  logic          start;

  logic          busy, done, duty_ok, err_timeout, err_unlock;
  logic [AW-1:0] high_acc, per_acc;
  logic          busy_t2, done_t2, duty_ok_t2, err_timeout_t2, err_unlock_t2;
  logic [AW-1:0] high_acc_t2, per_acc_t2;
  logic          busy_t3, done_t3, duty_ok_t3, err_timeout_t3, err_unlock_t3;
  logic [AW-1:0] high_acc_t3, per_acc_t3;

  int n_chk  = 0;
  int n_fail = 0;

  // Monitored-clock pattern generator: hi_len samples high, lo_len low
  int hi_len = 4;
  int lo_len = 4;
  int ph     = 0;
  bit pat_en = 1'b0;
  int done_cnt = 0;

  dcc_duty_monitor dut (
    .clk(clk), .rst_n(rst_n), .mon_clk_in(mon_clk_in), .locked_in(locked_in),
    .start(start), .busy(busy), .done(done), .high_acc(high_acc),
    .per_acc(per_acc), .duty_ok(duty_ok), .err_timeout(err_timeout),
    .err_unlock(err_unlock)
  );

  dcc_duty_monitor #(.TOL_SHIFT(2)) dut_t2 (
    .clk(clk), .rst_n(rst_n), .mon_clk_in(mon_clk_in), .locked_in(locked_in),
    .start(start), .busy(busy_t2), .done(done_t2), .high_acc(high_acc_t2),
    .per_acc(per_acc_t2), .duty_ok(duty_ok_t2), .err_timeout(err_timeout_t2),
    .err_unlock(err_unlock_t2)
  );

  dcc_duty_monitor #(.TOL_SHIFT(3)) dut_t3 (
    .clk(clk), .rst_n(rst_n), .mon_clk_in(mon_clk_in), .locked_in(locked_in),
    .start(start), .busy(busy_t3), .done(done_t3), .high_acc(high_acc_t3),
    .per_acc(per_acc_t3), .duty_ok(duty_ok_t3), .err_timeout(err_timeout_t3),
    .err_unlock(err_unlock_t3)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!pat_en) begin
      ph         <= 0;
      mon_clk_in <= 1'b0;
    end else begin
      mon_clk_in <= (ph < hi_len);
      ph         <= (ph + 1 >= hi_len + lo_len) ? 0 : ph + 1;
    end
  end

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  // Reference: a stable pattern measured over four whole periods
  function automatic bit model_ok(input int h, input int l, input int shift);
    int eh, ep, d;
    eh = 4 * h;
    ep = 4 * (h + l);
    d  = 2 * eh - ep;
    if (d < 0) d = -d;
    return d <= (ep >> shift);
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic set_pattern(input int h, input int l);
    hi_len = h;
    lo_len = l;
    pat_en = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; locked_in = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({busy, done, duty_ok, err_timeout, err_unlock} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b want=00000", {busy, done, duty_ok, err_timeout, err_unlock});
    end
    n_chk++;
    if (high_acc !== '0 || per_acc !== '0) begin
      n_fail++;
      $display("FAIL reset_acc got high=%0d per=%0d want 0/0", high_acc, per_acc);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Fixed patterns (balanced, skewed, tolerance boundary) then random ones
  task automatic test_patterns();
    int hs[9];
    int ls[9];
    int cyc, dc0, eh, ep;
    bit seen;
    logic [AW-1:0] hold_h;
    hs[0] = 4; ls[0] = 4;
    hs[1] = 3; ls[1] = 5;
    hs[2] = 5; ls[2] = 3;
    for (int i = 3; i < 9; i++) begin
      hs[i] = int'($urandom_range(1, 7));
      ls[i] = int'($urandom_range(1, 7));
    end
    locked_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_pattern(hs[i], ls[i]);
      eh  = 4 * hs[i];
      ep  = 4 * (hs[i] + ls[i]);
      dc0 = done_cnt;
      pulse_start();
      wait_done(400, cyc, seen);
      n_chk++;
      if (!seen) begin
        n_fail++;
        $display("FAIL pat%0d_done got=none want=done within 400", i);
      end
      n_chk++;
      if (high_acc !== AW'(eh) || per_acc !== AW'(ep)) begin
        n_fail++;
        $display("FAIL pat%0d_acc h=%0d l=%0d got high=%0d per=%0d want %0d/%0d",
                 i, hs[i], ls[i], high_acc, per_acc, eh, ep);
      end
      n_chk++;
      if (duty_ok !== model_ok(hs[i], ls[i], 4) || duty_ok_t2 !== model_ok(hs[i], ls[i], 2) ||
          duty_ok_t3 !== model_ok(hs[i], ls[i], 3)) begin
        n_fail++;
        $display("FAIL pat%0d_duty h=%0d l=%0d got s4/s2/s3=%b%b%b want %b%b%b", i, hs[i], ls[i],
                 duty_ok, duty_ok_t2, duty_ok_t3, model_ok(hs[i], ls[i], 4),
                 model_ok(hs[i], ls[i], 2), model_ok(hs[i], ls[i], 3));
      end
      n_chk++;
      if (err_timeout !== 1'b0 || err_unlock !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL pat%0d_flags got to=%b ul=%b busy=%b want 0/0/0", i, err_timeout, err_unlock, busy);
      end
      hold_h = high_acc;
      repeat (10) @(negedge clk);
      n_chk++;
      if (done !== 1'b0 || done_cnt - dc0 != 1 || high_acc !== hold_h) begin
        n_fail++;
        $display("FAIL pat%0d_hold got done=%b pulses=%0d high=%0d want 0/1/%0d", i, done,
                 done_cnt - dc0, high_acc, hold_h);
      end
    end
  endtask

  task automatic test_timeout();
    int cyc;
    bit seen;
    pat_en = 1'b0;
    locked_in = 1'b1;
    repeat (10) @(negedge clk);
    pulse_start();
    wait_done(5000, cyc, seen);
    // one WAIT_LOCK cycle, then 4095 cycles in ALIGN
    n_chk++;
    if (!seen || cyc != 4096) begin
      n_fail++;
      $display("FAIL timeout_latency got seen=%b cycles=%0d want 1/4096", seen, cyc);
    end
    n_chk++;
    if (err_timeout !== 1'b1 || err_unlock !== 1'b0 || duty_ok !== 1'b0 || per_acc !== '0) begin
      n_fail++;
      $display("FAIL timeout_flags got to=%b ul=%b ok=%b per=%0d want 1/0/0/0",
               err_timeout, err_unlock, duty_ok, per_acc);
    end
    @(negedge clk);
  endtask

  task automatic test_lock();
    int dc0;
    set_pattern(4, 4);
    locked_in = 1'b0;
    dc0 = done_cnt;
    pulse_start();
    repeat (50) @(negedge clk);
    n_chk++;
    if (busy !== 1'b1 || done_cnt != dc0 || per_acc !== '0 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_wait got busy=%b pulses=%0d per=%0d to=%b want 1/0/0/0",
               busy, done_cnt - dc0, per_acc, err_timeout);
    end
    locked_in = 1'b1;
    repeat (15) @(negedge clk);
    n_chk++;
    if (busy !== 1'b1 || per_acc == '0) begin
      n_fail++;
      $display("FAIL lock_run got busy=%b per=%0d want busy=1 per>0", busy, per_acc);
    end
    locked_in = 1'b0;
    @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || err_unlock !== 1'b1 || duty_ok !== 1'b0 || err_timeout !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_loss got done=%b ul=%b ok=%b to=%b busy=%b want 1/1/0/0/0",
               done, err_unlock, duty_ok, err_timeout, busy);
    end
    locked_in = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc, dc0;
    bit seen;
    set_pattern(4, 4);
    locked_in = 1'b1;
    dc0 = done_cnt;
    pulse_start();
    repeat (15) @(negedge clk);
    pulse_start();
    wait_done(400, cyc, seen);
    repeat (5) @(negedge clk);
    n_chk++;
    if (high_acc !== AW'(16) || per_acc !== AW'(32) || duty_ok !== 1'b1 || done_cnt - dc0 != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_ignored got high=%0d per=%0d ok=%b pulses=%0d busy=%b want 16/32/1/1/0",
               high_acc, per_acc, duty_ok, done_cnt - dc0, busy);
    end
    pulse_start();
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({busy, done, duty_ok, err_timeout, err_unlock} !== 5'b0 || high_acc !== '0 || per_acc !== '0) begin
      n_fail++;
      $display("FAIL midreset got flags=%b high=%0d per=%0d want 00000/0/0",
               {busy, done, duty_ok, err_timeout, err_unlock}, high_acc, per_acc);
    end
    rst_n = 1'b1;
    dc0 = done_cnt;
    repeat (60) @(negedge clk);
    n_chk++;
    if (done_cnt != dc0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_quiet got pulses=%0d busy=%b want 0/0", done_cnt - dc0, busy);
    end
    pulse_start();
    wait_done(400, cyc, seen);
    n_chk++;
    if (!seen || high_acc !== AW'(16) || per_acc !== AW'(32) || duty_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset got seen=%b high=%0d per=%0d ok=%b want 1/16/32/1",
               seen, high_acc, per_acc, duty_ok);
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_timeout();
    test_lock();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
